// File: rtl/rgmii_receive_assembler.sv
// rgmii_receive_assembler
//
// Receive-side byte assembler sitting between the RGMII DDR input cells and
// the packet parser. Builds bytes from rising/falling nibbles (1000 mode) or
// successive rising nibbles (10/100 mode), strips preamble and SFD, delays
// payload by one byte so the final byte can carry the end-of-frame flag, and
// decodes in-band link status during inter-frame gaps.
//
// Ports:
//   clock, reset_n                 receive clock, async active-low reset
//   enable                         frame acceptance, sampled at frame start
//   speed_code                     00=10M 01=100M 1x=1000M, latched at frame start
//   receive_data_rising/_falling   RXD nibbles from the DDR capture
//   receive_control_rising/_falling RX_CTL halves (RX_DV, RX_DV^RX_ER)
//   data_ready                     parser ready, sampled on the SFD byte only
//   data[8:0], data_enable         byte + last-byte flag, one-cycle strobe
//   frame_error                    with the last-byte strobe of a bad frame
//   frame_dropped                  frame discarded with no output
//   link_up, link_speed, link_full_duplex  in-band status
module rgmii_receive_assembler #(
    parameter int PREAMBLE_MAX_BYTES = 7,
    parameter int MAX_FRAME_BYTES    = 1522
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] speed_code,
    input  logic [3:0] receive_data_rising,
    input  logic [3:0] receive_data_falling,
    input  logic       receive_control_rising,
    input  logic       receive_control_falling,
    input  logic       data_ready,
    output logic [8:0] data,
    output logic       data_enable,
    output logic       frame_error,
    output logic       frame_dropped,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_full_duplex
);

    localparam int PW = $clog2(PREAMBLE_MAX_BYTES + 2);
    localparam int CW = $clog2(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    state_t          state, state_next;
    logic            gig, gig_next;
    logic            phase, phase_next;
    logic [3:0]      nib_low;
    logic [PW-1:0]   pre_cnt, pre_cnt_next, pre_base;
    logic [7:0]      hold, hold_next;
    logic            hold_vld, hold_vld_next;
    logic [CW-1:0]   byte_cnt, byte_cnt_next;
    logic            err, err_next;
    logic            armed;
    logic [8:0]      data_next;
    logic            en_next, ferr_next, drop_next;

    logic            rx_dv, rx_er, start, cur_gig, cur_phase, byte_valid, status_cap;
    logic [7:0]      cur_byte;

    assign rx_dv = receive_control_rising;
    assign rx_er = receive_control_rising ^ receive_control_falling;

    // A frame only starts after an rx_dv=0 has been seen since reset, so a
    // reset release in the middle of a frame never picks up its tail.
    assign start = (state == IDLE) && rx_dv && enable && armed;

    // The first rx_dv cycle already carries data, so on that cycle the mode
    // comes straight from speed_code and the nibble phase is forced to 0.
    assign cur_gig    = (state == IDLE) ? speed_code[1] : gig;
    assign cur_phase  = (state == IDLE) ? 1'b0 : phase;
    assign byte_valid = rx_dv && (cur_gig || cur_phase);
    assign cur_byte   = cur_gig ? {receive_data_falling, receive_data_rising}
                                : {receive_data_rising, nib_low};
    assign pre_base   = start ? '0 : pre_cnt;

    assign status_cap = ((state == IDLE) || (state == DROP)) && !rx_dv &&
                        !receive_control_falling &&
                        (receive_data_rising == receive_data_falling);

    always_comb begin
        state_next    = state;
        gig_next      = gig;
        phase_next    = (rx_dv && !cur_gig) ? ~cur_phase : cur_phase;
        pre_cnt_next  = pre_cnt;
        hold_next     = hold;
        hold_vld_next = hold_vld;
        byte_cnt_next = byte_cnt;
        err_next      = err;
        data_next     = data;
        en_next       = 1'b0;
        ferr_next     = 1'b0;
        drop_next     = 1'b0;

        case (state)
            IDLE: begin
                if (rx_dv) begin
                    state_next = start ? PREAMBLE : DROP;
                end
                if (start) begin
                    gig_next      = speed_code[1];
                    err_next      = rx_er;
                    pre_cnt_next  = '0;
                    hold_vld_next = 1'b0;
                    byte_cnt_next = '0;
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    drop_next  = 1'b1;
                end else if (rx_er) begin
                    err_next = 1'b1;
                end
            end
            PAYLOAD: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    if (hold_vld) begin
                        data_next = {1'b1, hold};
                        en_next   = 1'b1;
                        // phase=1 here means an unpaired nibble was left over
                        ferr_next = err | phase;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else begin
                    if (rx_er) begin
                        err_next = 1'b1;
                    end
                    if (byte_valid) begin
                        if (byte_cnt == CW'(MAX_FRAME_BYTES)) begin
                            // Oversize: close the frame on the held byte.
                            data_next  = {1'b1, hold};
                            en_next    = 1'b1;
                            ferr_next  = 1'b1;
                            state_next = DROP;
                        end else begin
                            if (hold_vld) begin
                                data_next = {1'b0, hold};
                                en_next   = 1'b1;
                            end
                            hold_next     = cur_byte;
                            hold_vld_next = 1'b1;
                            byte_cnt_next = byte_cnt + CW'(1);
                        end
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Preamble/SFD classification, shared by the start cycle and PREAMBLE.
        if (((state == PREAMBLE) || start) && byte_valid) begin
            if (cur_byte == 8'h55) begin
                if (pre_base == PW'(PREAMBLE_MAX_BYTES)) begin
                    state_next = DROP;
                    drop_next  = 1'b1;
                end else begin
                    pre_cnt_next = pre_base + PW'(1);
                end
            end else if ((cur_byte == 8'hD5) && data_ready) begin
                state_next = PAYLOAD;
            end else begin
                state_next = DROP;
                drop_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            gig              <= 1'b0;
            phase            <= 1'b0;
            nib_low          <= '0;
            pre_cnt          <= '0;
            hold             <= '0;
            hold_vld         <= 1'b0;
            byte_cnt         <= '0;
            err              <= 1'b0;
            armed            <= 1'b0;
            data             <= '0;
            data_enable      <= 1'b0;
            frame_error      <= 1'b0;
            frame_dropped    <= 1'b0;
            link_up          <= 1'b0;
            link_speed       <= '0;
            link_full_duplex <= 1'b0;
        end else begin
            state         <= state_next;
            gig           <= gig_next;
            phase         <= phase_next;
            pre_cnt       <= pre_cnt_next;
            hold          <= hold_next;
            hold_vld      <= hold_vld_next;
            byte_cnt      <= byte_cnt_next;
            err           <= err_next;
            data          <= data_next;
            data_enable   <= en_next;
            frame_error   <= ferr_next;
            frame_dropped <= drop_next;
            if (rx_dv && !cur_gig && !cur_phase) begin
                nib_low <= receive_data_rising;
            end
            if (!rx_dv) begin
                armed <= 1'b1;
            end
            if (status_cap) begin
                link_up          <= receive_data_rising[0];
                link_speed       <= receive_data_rising[2:1];
                link_full_duplex <= receive_data_rising[3];
            end
        end
    end

endmodule

// File: tb/tb_rgmii_receive_assembler.sv
module tb_rgmii_receive_assembler;

    localparam int MAXF = 64;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] speed_code;
    logic [3:0] rising, falling;
    logic       ctl_r, ctl_f;
    logic       data_ready;
    logic [8:0] data;
    logic       data_enable, frame_error, frame_dropped;
    logic       link_up, link_full_duplex;
    logic [1:0] link_speed;

    always #5 clock = ~clock;

    rgmii_receive_assembler #(
        .PREAMBLE_MAX_BYTES(7),
        .MAX_FRAME_BYTES(MAXF)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .speed_code(speed_code),
        .receive_data_rising(rising),
        .receive_data_falling(falling),
        .receive_control_rising(ctl_r),
        .receive_control_falling(ctl_f),
        .data_ready(data_ready),
        .data(data),
        .data_enable(data_enable),
        .frame_error(frame_error),
        .frame_dropped(frame_dropped),
        .link_up(link_up),
        .link_speed(link_speed),
        .link_full_duplex(link_full_duplex)
    );

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];   // {frame_error, last, byte}
    logic [9:0] e;
    int drops = 0, strobes = 0, cyc = 0, last_cyc = -1000, min_gap = 1000;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every strobe is matched against the next expected entry.
    always @(negedge clock) begin
        if (frame_dropped) drops++;
        if (data_enable) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got data=%h frame_error=%b expected no strobe", data, frame_error);
            end else begin
                e = exp_q.pop_front();
                if ({frame_error, data} !== e) begin
                    errors++;
                    $display("FAIL strobe got frame_error=%b data=%h expected frame_error=%b data=%h",
                             frame_error, data, e[9], e[8:0]);
                end
            end
            if (!data[8] && (cyc - last_cyc < min_gap)) min_gap = cyc - last_cyc;
            last_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_gig(input logic [7:0] b, input logic er);
        ctl_r = 1'b1; ctl_f = ~er; rising = b[3:0]; falling = b[7:4];
        tick();
    endtask

    task automatic send_nib(input logic [3:0] n);
        ctl_r = 1'b1; ctl_f = 1'b1; rising = n; falling = n;
        tick();
    endtask

    task automatic idle(input int n, input logic [3:0] r, input logic [3:0] f);
        ctl_r = 1'b0; ctl_f = 1'b0; rising = r; falling = f;
        repeat (n) tick();
    endtask

    task automatic pre_gig();
        repeat (7) send_gig(8'h55, 1'b0);
        send_gig(8'hD5, 1'b0);
    endtask

    task automatic pre_nib();
        repeat (15) send_nib(4'h5);
        send_nib(4'hD);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; speed_code = 2'b10; data_ready = 1'b1;
        ctl_r = 1'b0; ctl_f = 1'b0; rising = 4'h0; falling = 4'h0;
        repeat (3) tick();
        checks++;
        if ({data, data_enable, frame_error, frame_dropped} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h en=%b err=%b drop=%b expected all 0",
                     data, data_enable, frame_error, frame_dropped);
        end
        checks++;
        if ({link_up, link_speed, link_full_duplex} !== 4'h0) begin
            errors++;
            $display("FAIL reset_status got %b expected 0000", {link_up, link_speed, link_full_duplex});
        end
        reset_n = 1'b1;
        idle(3, 4'h0, 4'h0);
    endtask

    task automatic test_gig_frame();
        int s0, d0;
        s0 = strobes; d0 = drops;
        speed_code = 2'b10;
        for (int i = 1; i <= 64; i++) exp_q.push_back({1'b0, (i == 64), 8'(i)});
        pre_gig();
        for (int i = 1; i <= 64; i++) send_gig(8'(i), 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes - s0 != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gig_frame got strobes=%0d pending=%0d expected 64 and 0", strobes - s0, exp_q.size());
        end
        checks++;
        if (drops != d0) begin
            errors++;
            $display("FAIL gig_frame_drop got %0d expected 0", drops - d0);
        end
    endtask

    task automatic test_nibble();
        int s0;
        speed_code = 2'b01;
        s0 = strobes;
        exp_q.push_back({1'b0, 1'b0, 8'hA5});
        exp_q.push_back({1'b0, 1'b1, 8'h3C});
        pre_nib();
        send_nib(4'h5); send_nib(4'hA); send_nib(4'hC); send_nib(4'h3);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes - s0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nibble_frame got strobes=%0d pending=%0d expected 2 and 0", strobes - s0, exp_q.size());
        end
        // trailing unpaired nibble
        s0 = strobes;
        exp_q.push_back({1'b0, 1'b0, 8'hA5});
        exp_q.push_back({1'b1, 1'b1, 8'h3C});
        pre_nib();
        send_nib(4'h5); send_nib(4'hA); send_nib(4'hC); send_nib(4'h3); send_nib(4'h7);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes - s0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nibble_dangling got strobes=%0d pending=%0d expected 2 and 0", strobes - s0, exp_q.size());
        end
        // 10M, four bytes: payload strobes every second cycle
        speed_code = 2'b00;
        min_gap = 1000;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        exp_q.push_back({1'b0, 1'b0, 8'h33});
        exp_q.push_back({1'b0, 1'b1, 8'h44});
        pre_nib();
        send_nib(4'h1); send_nib(4'h1); send_nib(4'h2); send_nib(4'h2);
        send_nib(4'h3); send_nib(4'h3); send_nib(4'h4); send_nib(4'h4);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (min_gap != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nibble_spacing got gap=%0d pending=%0d expected 2 and 0", min_gap, exp_q.size());
        end
    endtask

    task automatic test_rx_er();
        speed_code = 2'b10;
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), (i == 9), 8'(8'hB0 + i)});
        pre_gig();
        for (int i = 0; i < 10; i++) send_gig(8'(8'hB0 + i), (i == 4));
        idle(3, 4'h0, 4'h0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rx_er_frame got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_not_ready();
        int s0, d0;
        speed_code = 2'b10;
        s0 = strobes; d0 = drops;
        repeat (7) send_gig(8'h55, 1'b0);
        data_ready = 1'b0;
        send_gig(8'hD5, 1'b0);
        data_ready = 1'b1;
        send_gig(8'h01, 1'b0); send_gig(8'h02, 1'b0); send_gig(8'h03, 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes != s0 || drops - d0 != 1) begin
            errors++;
            $display("FAIL not_ready got strobes=%0d drops=%0d expected 0 and 1", strobes - s0, drops - d0);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, (i == 4), 8'(8'h60 + i)});
        pre_gig();
        for (int i = 0; i < 5; i++) send_gig(8'(8'h60 + i), 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (exp_q.size() != 0 || strobes - s0 != 5) begin
            errors++;
            $display("FAIL after_not_ready got strobes=%0d pending=%0d expected 5 and 0", strobes - s0, exp_q.size());
        end
    endtask

    task automatic test_bad_preamble();
        int s0, d0;
        speed_code = 2'b10;
        s0 = strobes; d0 = drops;
        send_gig(8'h55, 1'b0); send_gig(8'h55, 1'b0); send_gig(8'h54, 1'b0);
        for (int i = 0; i < 5; i++) send_gig(8'hD5, 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes != s0 || drops - d0 != 1) begin
            errors++;
            $display("FAIL bad_preamble got strobes=%0d drops=%0d expected 0 and 1", strobes - s0, drops - d0);
        end
        // eight 0x55 bytes exceed the preamble limit
        d0 = drops;
        repeat (8) send_gig(8'h55, 1'b0);
        send_gig(8'hD5, 1'b0); send_gig(8'h01, 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes != s0 || drops - d0 != 1) begin
            errors++;
            $display("FAIL long_preamble got strobes=%0d drops=%0d expected 0 and 1", strobes - s0, drops - d0);
        end
    endtask

    task automatic test_oversize();
        int s0, d0;
        speed_code = 2'b10;
        s0 = strobes; d0 = drops;
        for (int i = 1; i <= 64; i++) exp_q.push_back({(i == 64), (i == 64), 8'(8'h80 + i)});
        pre_gig();
        for (int i = 1; i <= 70; i++) send_gig(8'(8'h80 + i), 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes - s0 != 64 || exp_q.size() != 0 || drops != d0) begin
            errors++;
            $display("FAIL oversize got strobes=%0d pending=%0d drops=%0d expected 64, 0, 0",
                     strobes - s0, exp_q.size(), drops - d0);
        end
    endtask

    task automatic test_status();
        idle(3, 4'b1101, 4'b1101);
        checks++;
        if (link_up !== 1'b1) begin
            errors++; $display("FAIL status_link_up got %b expected 1", link_up);
        end
        checks++;
        if (link_speed !== 2'b10) begin
            errors++; $display("FAIL status_speed got %b expected 10", link_speed);
        end
        checks++;
        if (link_full_duplex !== 1'b1) begin
            errors++; $display("FAIL status_duplex got %b expected 1", link_full_duplex);
        end
        idle(3, 4'b0000, 4'b1101);
        checks++;
        if ({link_up, link_speed, link_full_duplex} !== 4'b1101) begin
            errors++;
            $display("FAIL status_hold got %b expected 1101", {link_up, link_speed, link_full_duplex});
        end
        idle(3, 4'b0010, 4'b0010);
        checks++;
        if ({link_up, link_speed, link_full_duplex} !== 4'b0010) begin
            errors++;
            $display("FAIL status_update got %b expected 0010", {link_up, link_speed, link_full_duplex});
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0, d0;
        speed_code = 2'b10;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b0, 8'(8'hC1 + i)});
        pre_gig();
        for (int i = 0; i < 5; i++) send_gig(8'(8'hC1 + i), 1'b0);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data, data_enable, frame_error, frame_dropped, link_up, link_speed, link_full_duplex} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got data=%h en=%b err=%b drop=%b status=%b expected all 0",
                     data, data_enable, frame_error, frame_dropped, {link_up, link_speed, link_full_duplex});
        end
        tick();
        reset_n = 1'b1;
        s0 = strobes; d0 = drops;
        for (int i = 0; i < 4; i++) send_gig(8'(8'hE0 + i), 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes != s0 || drops != d0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_reset_tail got strobes=%0d drops=%0d pending=%0d expected 0, 0, 0",
                     strobes - s0, drops - d0, exp_q.size());
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i == 3), 8'(8'h70 + i)});
        pre_gig();
        for (int i = 0; i < 4; i++) send_gig(8'(8'h70 + i), 1'b0);
        idle(3, 4'h0, 4'h0);
        checks++;
        if (strobes - s0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_reset_frame got strobes=%0d pending=%0d expected 4 and 0", strobes - s0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_gig_frame();
        test_nibble();
        test_rx_er();
        test_not_ready();
        test_bad_preamble();
        test_oversize();
        test_status();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
